// File: rtl/bm_pkg.sv
// Shared widths, saturation constant and result record for the block-matching winner-take-all path.
package bm_pkg;

    localparam int unsigned COST_W = 16;
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned NDISP  = 32;

    localparam logic [COST_W-1:0] COST_MAX = {COST_W{1'b1}};

    typedef struct packed {
        logic [COST_W-1:0] min_cost;
        logic [IDX_W-1:0]  idx;
        logic [COST_W-1:0] l_cost;
        logic [COST_W-1:0] r_cost;
    } result_t;

endpackage

// File: rtl/bm_min_update.sv
// One search step: folds the current cost beat into the running minimum and its left/right neighbours.
module bm_min_update #(
    parameter int unsigned COST_W = bm_pkg::COST_W,
    parameter int unsigned IDX_W  = bm_pkg::IDX_W
) (
    input  logic              sop_i,
    input  logic [COST_W-1:0] cost_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [COST_W-1:0] min_i,
    input  logic [IDX_W-1:0]  midx_i,
    input  logic [COST_W-1:0] l_i,
    input  logic [COST_W-1:0] r_i,
    input  logic [COST_W-1:0] prev_i,
    input  logic              pend_i,
    output logic [COST_W-1:0] min_c,
    output logic [IDX_W-1:0]  midx_c,
    output logic [COST_W-1:0] l_c,
    output logic [COST_W-1:0] r_c,
    output logic [COST_W-1:0] prev_c,
    output logic              pend_c
);

    localparam logic [COST_W-1:0] CMAX = {COST_W{1'b1}};

    // Strict less-than keeps the lowest index on ties; a new minimum re-arms the right-neighbour capture.
    always_comb begin
        min_c  = min_i;
        midx_c = midx_i;
        l_c    = l_i;
        r_c    = r_i;
        pend_c = pend_i;
        prev_c = cost_i;
        if (sop_i) begin
            min_c  = cost_i;
            midx_c = '0;
            l_c    = CMAX;
            pend_c = 1'b1;
        end else if (cost_i < min_i) begin
            min_c  = cost_i;
            midx_c = idx_i;
            l_c    = prev_i;
            pend_c = 1'b1;
        end else if (pend_i) begin
            r_c    = cost_i;
            pend_c = 1'b0;
        end
    end

endmodule

// File: rtl/bm_find_min.sv
// Serial winner-take-all over per-pixel disparity costs; emits min, its index and both neighbour costs.
module bm_find_min #(
    parameter int unsigned COST_W = bm_pkg::COST_W,
    parameter int unsigned IDX_W  = bm_pkg::IDX_W,
    parameter int unsigned NDISP  = bm_pkg::NDISP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vin,
    input  logic              sop,
    input  logic              eop,
    input  logic [COST_W-1:0] cost,
    output logic [COST_W-1:0] det_min,
    output logic [IDX_W-1:0]  det_idx,
    output logic [COST_W-1:0] det_l,
    output logic [COST_W-1:0] det_r,
    output logic              vout,
    output logic              err
);

    localparam int unsigned       CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(NDISP - 1);
    localparam logic [COST_W-1:0] CMAX  = {COST_W{1'b1}};

    logic              in_pkt_q, in_pkt_d;
    logic [CNT_W-1:0]  idx_cnt_q, idx_cnt_d;
    logic [COST_W-1:0] min_q, min_d, l_q, l_d, r_q, r_d, prev_q, prev_d;
    logic [IDX_W-1:0]  midx_q, midx_d;
    logic              pend_q, pend_d;
    logic [COST_W-1:0] det_min_q, det_min_d, det_l_q, det_l_d, det_r_q, det_r_d;
    logic [IDX_W-1:0]  det_idx_q, det_idx_d;
    logic              vout_q, vout_d, err_q, err_d;

    logic [CNT_W-1:0]  cur_idx_c;
    logic [COST_W-1:0] upd_min_c, upd_l_c, upd_r_c, upd_prev_c;
    logic [IDX_W-1:0]  upd_midx_c;
    logic              upd_pend_c;

    assign cur_idx_c = sop ? '0 : idx_cnt_q;

    bm_min_update #(
        .COST_W (COST_W),
        .IDX_W  (IDX_W)
    ) u_upd (
        .sop_i  (sop),
        .cost_i (cost),
        .idx_i  (IDX_W'(cur_idx_c)),
        .min_i  (min_q),
        .midx_i (midx_q),
        .l_i    (l_q),
        .r_i    (r_q),
        .prev_i (prev_q),
        .pend_i (pend_q),
        .min_c  (upd_min_c),
        .midx_c (upd_midx_c),
        .l_c    (upd_l_c),
        .r_c    (upd_r_c),
        .prev_c (upd_prev_c),
        .pend_c (upd_pend_c)
    );

    // Packet framing, error strobes and result capture; idle beats and out-of-packet beats hold state.
    always_comb begin
        in_pkt_d  = in_pkt_q;
        idx_cnt_d = idx_cnt_q;
        min_d     = min_q;
        midx_d    = midx_q;
        l_d       = l_q;
        r_d       = r_q;
        prev_d    = prev_q;
        pend_d    = pend_q;
        det_min_d = '0;
        det_idx_d = '0;
        det_l_d   = '0;
        det_r_d   = '0;
        vout_d    = 1'b0;
        err_d     = 1'b0;
        if (vin && (sop || in_pkt_q)) begin
            min_d     = upd_min_c;
            midx_d    = upd_midx_c;
            l_d       = upd_l_c;
            r_d       = upd_r_c;
            prev_d    = upd_prev_c;
            pend_d    = upd_pend_c;
            idx_cnt_d = cur_idx_c + CNT_W'(1);
            in_pkt_d  = 1'b1;
            if (sop && in_pkt_q) begin
                err_d = 1'b1;
            end
            if (eop) begin
                in_pkt_d  = 1'b0;
                vout_d    = 1'b1;
                det_min_d = upd_min_c;
                det_idx_d = upd_midx_c;
                det_l_d   = upd_l_c;
                det_r_d   = upd_pend_c ? CMAX : upd_r_c;
                if (cur_idx_c != LAST) begin
                    err_d = 1'b1;
                end
            end else if (cur_idx_c == LAST) begin
                in_pkt_d = 1'b0;
                err_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_pkt_q  <= 1'b0;
            idx_cnt_q <= '0;
            min_q     <= '0;
            midx_q    <= '0;
            l_q       <= '0;
            r_q       <= '0;
            prev_q    <= '0;
            pend_q    <= 1'b0;
            det_min_q <= '0;
            det_idx_q <= '0;
            det_l_q   <= '0;
            det_r_q   <= '0;
            vout_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            in_pkt_q  <= in_pkt_d;
            idx_cnt_q <= idx_cnt_d;
            min_q     <= min_d;
            midx_q    <= midx_d;
            l_q       <= l_d;
            r_q       <= r_d;
            prev_q    <= prev_d;
            pend_q    <= pend_d;
            det_min_q <= det_min_d;
            det_idx_q <= det_idx_d;
            det_l_q   <= det_l_d;
            det_r_q   <= det_r_d;
            vout_q    <= vout_d;
            err_q     <= err_d;
        end
    end

    assign det_min = det_min_q;
    assign det_idx = det_idx_q;
    assign det_l   = det_l_q;
    assign det_r   = det_r_q;
    assign vout    = vout_q;
    assign err     = err_q;

endmodule

// File: tb/tb_bm_find_min.sv
// Bench for bm_find_min: directed table, framing corner cases and random packets against a reference model.
module tb_bm_find_min;
    import bm_pkg::*;

    localparam int unsigned CW = 16;
    localparam int unsigned IW = 5;
    localparam int unsigned ND = 32;
    localparam logic [CW-1:0] MAXC = 16'hFFFF;

    typedef logic [CW-1:0] cq_t[$];
    typedef struct {
        result_t res;
        logic    err;
    } exp_t;
    typedef struct {
        int      kind;
        result_t exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          vin = 1'b0;
    logic          sop = 1'b0;
    logic          eop = 1'b0;
    logic [CW-1:0] cost = '0;
    logic [CW-1:0] det_min, det_l, det_r;
    logic [IW-1:0] det_idx;
    logic          vout, err;

    exp_t exp_q[$];
    int   err_exp_n = 0;
    logic done = 1'b0;

    int   n_chk = 0;
    int   n_fail = 0;
    int   exp_rd = 0;
    int   err_seen_n = 0;

    bm_find_min #(.COST_W(CW), .IDX_W(IW), .NDISP(ND)) dut (
        .clk     (clk),
        .rst     (rst),
        .vin     (vin),
        .sop     (sop),
        .eop     (eop),
        .cost    (cost),
        .det_min (det_min),
        .det_idx (det_idx),
        .det_l   (det_l),
        .det_r   (det_r),
        .vout    (vout),
        .err     (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic result_t ref_model(input cq_t c);
        result_t r;
        int best = 0;
        for (int i = 1; i < c.size(); i++)
            if (c[i] < c[best]) best = i;
        r.min_cost = c[best];
        r.idx      = IW'(best);
        r.l_cost   = (best == 0) ? MAXC : c[best-1];
        r.r_cost   = (best == c.size() - 1) ? MAXC : c[best+1];
        return r;
    endfunction

    function automatic cq_t build(input int kind);
        cq_t c;
        for (int i = 0; i < int'(ND); i++) c.push_back(16'd200);
        case (kind)
            1: begin c[0] = 16'd100; c[1] = 16'd90; c[2] = 16'd80; c[3] = 16'd70; c[4] = 16'd75; c[5] = 16'd85; end
            2: begin c[0] = 16'd10; c[1] = 16'd20; end
            3: begin c[30] = 16'd9; c[31] = 16'd5; end
            default: begin c[4] = 16'd50; c[5] = 16'd60; c[9] = 16'd50; end
        endcase
        return c;
    endfunction

    function automatic cq_t rand_costs(input int n, input int hi);
        cq_t c;
        for (int i = 0; i < n; i++) c.push_back(CW'($urandom_range(hi, 0)));
        return c;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            vin = 1'b0; sop = 1'($urandom); eop = 1'($urandom); cost = CW'($urandom);
        end
    endtask

    task automatic beat(input logic [CW-1:0] c, input logic s, input logic e);
        @(posedge clk); #1;
        vin = 1'b1; sop = s; eop = e; cost = c;
    endtask

    task automatic send(input cq_t c, input logic with_eop, input int gap_pct);
        for (int i = 0; i < c.size(); i++) begin
            if (i != 0 && int'($urandom_range(99, 0)) < gap_pct) idle(int'($urandom_range(3, 1)));
            beat(c[i], i == 0, with_eop && (i == c.size() - 1));
        end
    endtask

    task automatic expect_res(input result_t r, input logic e);
        exp_t x;
        x.res = r;
        x.err = e;
        exp_q.push_back(x);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Single checker process: owns every counter, compares each output cycle against queued expectations.
    always @(negedge clk) begin
        if (done) begin
            chk("all_results_seen", 64'(exp_rd), 64'(exp_q.size()));
            chk("all_err_seen", 64'(err_seen_n), 64'(err_exp_n));
            $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
            $finish;
        end else if (rst) begin
            chk("reset_outputs", {11'd0, det_min, det_idx, det_l, det_r, vout, err}, 64'd0);
        end else if (vout) begin
            if (exp_rd >= exp_q.size()) begin
                chk("unexpected_vout", 64'(vout), 64'd0);
            end else begin
                chk("det_min", 64'(det_min), 64'(exp_q[exp_rd].res.min_cost));
                chk("det_idx", 64'(det_idx), 64'(exp_q[exp_rd].res.idx));
                chk("det_l",   64'(det_l),   64'(exp_q[exp_rd].res.l_cost));
                chk("det_r",   64'(det_r),   64'(exp_q[exp_rd].res.r_cost));
                chk("err_with_vout", 64'(err), 64'(exp_q[exp_rd].err));
                exp_rd++;
            end
        end else begin
            chk("idle_det_zero", {11'd0, det_min, det_idx, det_l, det_r}, 64'd0);
            if (err) begin
                chk("err_expected", 64'(err_seen_n < err_exp_n), 64'd1);
                err_seen_n++;
            end
        end
    end

    initial begin
        vec_t vec[4];
        cq_t  c, c2;
        result_t r;

        vec[0].kind = 1; vec[0].exp = '{min_cost: 16'd70, idx: 5'd3,  l_cost: 16'd80,  r_cost: 16'd75};
        vec[1].kind = 2; vec[1].exp = '{min_cost: 16'd10, idx: 5'd0,  l_cost: MAXC,    r_cost: 16'd20};
        vec[2].kind = 3; vec[2].exp = '{min_cost: 16'd5,  idx: 5'd31, l_cost: 16'd9,   r_cost: MAXC};
        vec[3].kind = 4; vec[3].exp = '{min_cost: 16'd50, idx: 5'd4,  l_cost: 16'd200, r_cost: 16'd60};

        idle(3);
        @(posedge clk); #1; rst = 1'b0;
        idle(2);

        // Directed table.
        for (int i = 0; i < 4; i++) begin
            expect_res(vec[i].exp, 1'b0);
            send(build(vec[i].kind), 1'b1, 0);
            idle(1);
        end

        // Single-beat packet: sop and eop together.
        expect_res('{min_cost: 16'd1234, idx: 5'd0, l_cost: MAXC, r_cost: MAXC}, 1'b1);
        c = {16'd1234};
        send(c, 1'b1, 0);
        idle(2);

        // Short packet closed early by eop.
        c = rand_costs(5, 63);
        expect_res(ref_model(c), 1'b1);
        send(c, 1'b1, 20);
        idle(2);

        // Overlong packet with no eop, then a stray out-of-packet eop beat that must be ignored.
        err_exp_n++;
        send(rand_costs(int'(ND), 1000), 1'b0, 0);
        beat(16'd3, 1'b0, 1'b1);
        idle(3);

        // sop while a packet is open: old packet dropped, new one completes.
        send(rand_costs(10, 500), 1'b0, 0);
        err_exp_n++;
        c = rand_costs(int'(ND), 500);
        expect_res(ref_model(c), 1'b0);
        send(c, 1'b1, 10);
        idle(2);

        // Asynchronous reset mid-packet: nothing emitted for the partial packet.
        send(rand_costs(7, 500), 1'b0, 0);
        @(posedge clk); #2; rst = 1'b1; vin = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        idle(2);
        c = rand_costs(int'(ND), 500);
        expect_res(ref_model(c), 1'b0);
        send(c, 1'b1, 0);
        idle(2);

        // Random packets with gaps, narrow cost range for ties, back-to-back boundaries.
        for (int p = 0; p < 20; p++) begin
            c2 = rand_costs(int'(ND), (p % 2 == 0) ? 63 : 65535);
            r = ref_model(c2);
            expect_res(r, 1'b0);
            send(c2, 1'b1, 25);
            if ($urandom_range(1, 0) == 1) idle(int'($urandom_range(2, 1)));
        end
        idle(4);
        done = 1'b1;
        idle(3);
    end

endmodule
